hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipelined core: F, D, E, M, W.
- Observes register addresses from D and E, destination/writeback info from E/M/W, branch resolution in E and the data-memory handshake in M.
- Drives per-stage stall and flush enables plus E-stage operand forwarding selects.
- Holds a memory-wait FSM with timeout and saturating performance counters.

Parameters:
- MEM_TIMEOUT, 16, maximum cycles spent in MEM_WAIT before mem_err is raised and the FSM returns to RUN.
- CNT_W, 16, width of the stall_cycles and flush_events counters.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- rs1D, rs2D  in  5  source register addresses of the instruction in D
- rs1E, rs2E  in  5  source register addresses of the instruction in E
- rdE  in  5  destination of the instruction in E
- regwriteE  in  1  E instruction writes the register file
- resultsrcE  in  1  E instruction is a load (result comes from memory)
- rdM, rdW  in  5  destinations in M and W
- regwriteM, regwriteW  in  1  M/W instructions write the register file
- pcsrcE  in  1  branch/jump taken, resolved in E
- mem_req  in  1  M-stage instruction accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- stallF, stallD, stallE, stallM  out  1  hold the pipeline register feeding that stage
- flushD, flushE  out  1  bubble the D / E pipeline register
- forwardAE, forwardBE  out  2  E operand select: 00 RF, 01 W result, 10 M ALU result
- mem_err  out  1  sticky: a memory timeout occurred
- stall_cycles  out  CNT_W  saturating count of cycles with stallF=1
- flush_events  out  CNT_W  saturating count of cycles with flushE=1 caused by pcsrcE

Behaviour:
- Reset, synchronous while rst=1:
  - state<=RUN; timeout counter<=0; mem_err<=0; both performance counters<=0.
  - While rst=1 the outputs are forced: all stalls 0, flushD=flushE=1, forwardAE=forwardBE=00.
- Forwarding (combinational, evaluated every cycle):
  - forwardAE=10 if regwriteM && rdM!=0 && rdM==rs1E.
  - Else forwardAE=01 if regwriteW && rdW!=0 && rdW==rs1E.
  - Else forwardAE=00.
  - forwardBE is identical using rs2E. M has priority over W.
- lwstall = resultsrcE && regwriteE && rdE!=0 && (rdE==rs1D || rdE==rs2D).
- freeze = (state==RUN && mem_req && !mem_ready) || (state==MEM_WAIT && !mem_ready && !timeout_hit).
- Output priority, highest first:
  1. freeze: stallF=stallD=stallE=stallM=1; flushD=flushE=0. Branch and load-use are deferred. E is held, so pcsrcE persists and is acted on in the release cycle.
  2. pcsrcE: flushD=flushE=1; no stalls. This also covers simultaneous lwstall, because the D instruction is squashed.
  3. lwstall: stallF=stallD=1, flushE=1 for exactly one cycle. Next cycle the load is in M, so lwstall clears and forwarding selects 10 or 01.
  4. Otherwise: all stalls and flushes are 0.
- FSM:
  - RUN -> MEM_WAIT when mem_req && !mem_ready; the timeout counter loads 1.
  - MEM_WAIT -> RUN on mem_ready. That cycle is not frozen, so the pipeline advances.
  - In MEM_WAIT without mem_ready, the counter increments. When counter==MEM_TIMEOUT (timeout_hit), freeze deasserts that cycle, mem_err<=1 (sticky until rst), next state is RUN and the counter clears.
  - mem_req && mem_ready in RUN means zero-wait access: no freeze, stay in RUN.
- Counters:
  - stall_cycles increments on every cycle with stallF=1 (freeze or lwstall).
  - flush_events increments on every cycle where case 2 applies.
  - Both saturate at all-ones; neither wraps.
  - No counting while rst=1.
- Register x0 never forwards and never causes a stall.
- Reset mid-MEM_WAIT returns to RUN immediately; mem_err clears.

Decomposition:
- hazard_pkg holds:
  - typedef fwd_sel_t: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - typedef enum state_t: RUN, MEM_WAIT.
  - Register address width constant REG_AW=5.
- One sub-module, fwd_sel: given rsE, rdM, regwriteM, rdW, regwriteW, returns fwd_sel_t. It is instantiated twice, for operands A and B.

Test Plan:
- Forwarding priority: rs1E=5, rdM=5, regwriteM=1, rdW=5, regwriteW=1 -> forwardAE=10. Same with regwriteM=0 -> 01. Same with rdM=rdW=0 -> 00.
- Load-use: resultsrcE=1, regwriteE=1, rdE=7, rs2D=7 -> stallF=stallD=flushE=1 for one cycle, stall_cycles increments by 1. With rdE=0 -> no stall.
- Branch vs load-use: pcsrcE=1 together with the lwstall condition -> flushD=flushE=1, stallF=0, flush_events increments by 1.
- Memory wait: mem_req=1, mem_ready low for 3 cycles then high -> all four stalls high for 3 cycles, state returns to RUN on the 4th cycle with stalls 0, stall_cycles=3. A branch held in E during the wait flushes on the release cycle.
- Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready held 0 -> freeze lasts 4 cycles, mem_err=1 from the following cycle and stays set. A subsequent rst clears mem_err and the counters.
- Saturation: CNT_W=4, hold lwstall true for 20 cycles -> stall_cycles stops at 15. rst pulse -> counters 0, flushD=flushE=1 during reset.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding select for one E-stage source register.
// The M-stage ALU result is newer than the W-stage result, so it wins.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [REG_AW-1:0] rs_e_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic              regwrite_m_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              regwrite_w_i,
  output fwd_sel_t          sel_o
);

  // Pick the youngest in-flight writer of rs_e_i; x0 is never forwarded.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves sel_o unassigned, which would infer a latch.
    sel_o = FWD_RF;
    if (regwrite_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i)) begin
      sel_o = FWD_MEM;
    end else if (regwrite_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: forwarding,
// load-use stall, branch flush, data-memory wait FSM with timeout, and
// saturating stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs1D,
  input  logic [4:0]        rs2D,
  input  logic [4:0]        rs1E,
  input  logic [4:0]        rs2E,
  input  logic [4:0]        rdE,
  input  logic              regwriteE,
  input  logic              resultsrcE,
  input  logic [4:0]        rdM,
  input  logic [4:0]        rdW,
  input  logic              regwriteM,
  input  logic              regwriteW,
  input  logic              pcsrcE,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushD,
  output logic              flushE,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
);

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

  state_t           state_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic             mem_err_q;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  fwd_sel_t fwd_a, fwd_b;
  logic     lwstall, timeout_hit, freeze, branch_flush;

  fwd_sel u_fwd_a (
    .rs_e_i       (rs1E),
    .rd_m_i       (rdM),
    .regwrite_m_i (regwriteM),
    .rd_w_i       (rdW),
    .regwrite_w_i (regwriteW),
    .sel_o        (fwd_a)
  );

  fwd_sel u_fwd_b (
    .rs_e_i       (rs2E),
    .rd_m_i       (rdM),
    .regwrite_m_i (regwriteM),
    .rd_w_i       (rdW),
    .regwrite_w_i (regwriteW),
    .sel_o        (fwd_b)
  );

  assign lwstall     = resultsrcE && regwriteE && (rdE != '0) &&
                       ((rdE == rs1D) || (rdE == rs2D));
  assign timeout_hit = (state_q == MEM_WAIT) && (to_cnt_q == TO_W'(MEM_TIMEOUT));
  assign freeze      = ((state_q == RUN) && mem_req && !mem_ready) ||
                       ((state_q == MEM_WAIT) && !mem_ready && !timeout_hit);

  // Stall/flush priority: reset, memory freeze, taken branch, load-use.
  always_comb begin
    stallF       = 1'b0;
    stallD       = 1'b0;
    stallE       = 1'b0;
    stallM       = 1'b0;
    flushD       = 1'b0;
    flushE       = 1'b0;
    branch_flush = 1'b0;
    if (rst) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (freeze) begin
      // E is held, so a resolved branch stays visible until release.
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
    end else if (pcsrcE) begin
      // Squashing D also removes any load-use dependency it carried.
      flushD       = 1'b1;
      flushE       = 1'b1;
      branch_flush = 1'b1;
    end else if (lwstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  assign forwardAE = rst ? FWD_RF : fwd_a;
  assign forwardBE = rst ? FWD_RF : fwd_b;

  // Saturating next values; stallF and branch_flush are already 0 in reset.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (stallF && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
    if (branch_flush && (flush_events_q != {CNT_W{1'b1}})) begin
      flush_events_d = flush_events_q + 1'b1;
    end
  end

  // Memory-wait FSM with timeout counter and sticky error flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q   <= RUN;
      to_cnt_q  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_req && !mem_ready) begin
            state_q  <= MEM_WAIT;
            to_cnt_q <= TO_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state_q  <= RUN;
            to_cnt_q <= '0;
          end else if (timeout_hit) begin
            state_q   <= RUN;
            to_cnt_q  <= '0;
            mem_err_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table-driven single-cycle vectors
// plus hand-written multi-cycle sequences, with an expected-output queue
// and a small saturating counter model.
module tb_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] rs1D = '0, rs2D = '0, rs1E = '0, rs2E = '0, rdE = '0, rdM = '0, rdW = '0;
  logic regwriteE = 0, resultsrcE = 0, regwriteM = 0, regwriteW = 0;
  logic pcsrcE = 0, mem_req = 0, mem_ready = 0;
  logic stallF, stallD, stallE, stallM, flushD, flushE, mem_err;
  logic [1:0] forwardAE, forwardBE;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .regwriteE(regwriteE), .resultsrcE(resultsrcE),
    .rdM(rdM), .rdW(rdW), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .pcsrcE(pcsrcE), .mem_req(mem_req), .mem_ready(mem_ready),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] stall;  // {F, D, E, M}
    logic [1:0] flush;  // {D, E}
    logic [1:0] fa;
    logic [1:0] fb;
  } out_t;

  typedef struct {
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       regwriteE, resultsrcE, regwriteM, regwriteW;
    logic       pcsrcE, mem_req, mem_ready;
    out_t       exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  out_t sb[$];
  logic [CNT_W-1:0] exp_sc = '0, exp_fc = '0;
  logic exp_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t idle();
    vec_t v;
    v.rs1D = '0; v.rs2D = '0; v.rs1E = '0; v.rs2E = '0;
    v.rdE = '0; v.rdM = '0; v.rdW = '0;
    v.regwriteE = 0; v.resultsrcE = 0; v.regwriteM = 0; v.regwriteW = 0;
    v.pcsrcE = 0; v.mem_req = 0; v.mem_ready = 0;
    v.exp.stall = '0; v.exp.flush = '0; v.exp.fa = '0; v.exp.fb = '0;
    return v;
  endfunction

  // Forwarding vector: no hazards, only expected selects.
  function automatic vec_t fv(input logic [4:0] r1e, r2e, rdm, input logic rwm,
                              input logic [4:0] rdw, input logic rww,
                              input logic [1:0] ea, eb);
    vec_t v = idle();
    v.rs1E = r1e; v.rs2E = r2e; v.rdM = rdm; v.regwriteM = rwm;
    v.rdW = rdw; v.regwriteW = rww; v.exp.fa = ea; v.exp.fb = eb;
    return v;
  endfunction

  // Hazard vector: D sources, E load info, branch, memory handshake.
  function automatic vec_t hv(input logic [4:0] r1d, r2d, rde, input logic rwe, rse, pc,
                              input logic req, rdy,
                              input logic [3:0] es, input logic [1:0] ef);
    vec_t v = idle();
    v.rs1D = r1d; v.rs2D = r2d; v.rdE = rde; v.regwriteE = rwe; v.resultsrcE = rse;
    v.pcsrcE = pc; v.mem_req = req; v.mem_ready = rdy;
    v.exp.stall = es; v.exp.flush = ef;
    return v;
  endfunction

  // One cycle: drive at negedge, push expectation, compare 1 time unit later.
  task automatic apply(input vec_t v, input string name);
    out_t e;
    @(negedge clk);
    rs1D = v.rs1D; rs2D = v.rs2D; rs1E = v.rs1E; rs2E = v.rs2E;
    rdE = v.rdE; rdM = v.rdM; rdW = v.rdW;
    regwriteE = v.regwriteE; resultsrcE = v.resultsrcE;
    regwriteM = v.regwriteM; regwriteW = v.regwriteW;
    pcsrcE = v.pcsrcE; mem_req = v.mem_req; mem_ready = v.mem_ready;
    sb.push_back(v.exp);
    #1;
    check({name, ".stall_cycles"}, 32'(stall_cycles), 32'(exp_sc));
    check({name, ".flush_events"}, 32'(flush_events), 32'(exp_fc));
    check({name, ".mem_err"}, 32'(mem_err), 32'(exp_err));
    e = sb.pop_front();
    check({name, ".stalls"}, 32'({stallF, stallD, stallE, stallM}), 32'(e.stall));
    check({name, ".flushes"}, 32'({flushD, flushE}), 32'(e.flush));
    check({name, ".forwardAE"}, 32'(forwardAE), 32'(e.fa));
    check({name, ".forwardBE"}, 32'(forwardBE), 32'(e.fb));
    if (e.stall[3] && exp_sc != CMAX) exp_sc = exp_sc + 1'b1;
    if (e.flush == 2'b11 && e.stall == 4'b0000 && v.pcsrcE && exp_fc != CMAX)
      exp_fc = exp_fc + 1'b1;
  endtask

  // One reset cycle with hazard-provoking inputs; outputs must be forced.
  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b1;
    rs1E = 5'd5; rdM = 5'd5; regwriteM = 1'b1;
    rs2D = 5'd7; rdE = 5'd7; regwriteE = 1'b1; resultsrcE = 1'b1;
    mem_req = 1'b1; mem_ready = 1'b0;
    #1;
    check({name, ".rst_stalls"}, 32'({stallF, stallD, stallE, stallM}), 32'h0);
    check({name, ".rst_flushes"}, 32'({flushD, flushE}), 32'h3);
    check({name, ".rst_forwardAE"}, 32'(forwardAE), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rs1E = '0; rdM = '0; regwriteM = 0; rs2D = '0; rdE = '0;
    regwriteE = 0; resultsrcE = 0; mem_req = 0; mem_ready = 0; pcsrcE = 0;
    exp_sc = '0; exp_fc = '0; exp_err = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[15];
    vec_t lw;
    tbl[0]  = fv(5, 0, 5, 1, 5, 1, 2'b10, 2'b00);  // M beats W
    tbl[1]  = fv(5, 0, 5, 0, 5, 1, 2'b01, 2'b00);  // M not writing -> W
    tbl[2]  = fv(5, 0, 0, 1, 0, 1, 2'b00, 2'b00);  // rdM=rdW=0
    tbl[3]  = fv(0, 0, 0, 1, 0, 1, 2'b00, 2'b00);  // x0 never forwards
    tbl[4]  = fv(3, 9, 9, 1, 3, 1, 2'b01, 2'b10);  // A from W, B from M
    tbl[5]  = fv(4, 4, 7, 1, 7, 1, 2'b00, 2'b00);  // no match
    tbl[6]  = fv(6, 6, 6, 1, 2, 1, 2'b10, 2'b10);
    tbl[7]  = fv(8, 8, 1, 1, 8, 0, 2'b00, 2'b00);  // W not writing
    tbl[8]  = hv(0, 7, 7, 1, 1, 0, 0, 0, 4'b1100, 2'b01);  // load-use via rs2D
    tbl[9]  = hv(7, 0, 7, 1, 1, 0, 0, 0, 4'b1100, 2'b01);  // load-use via rs1D
    tbl[10] = hv(0, 0, 0, 1, 1, 0, 0, 0, 4'b0000, 2'b00);  // rdE=0 never stalls
    tbl[11] = hv(7, 7, 7, 0, 1, 0, 0, 0, 4'b0000, 2'b00);  // no regwrite
    tbl[12] = hv(7, 7, 7, 1, 0, 0, 0, 0, 4'b0000, 2'b00);  // not a load
    tbl[13] = hv(3, 7, 7, 1, 1, 1, 0, 0, 4'b0000, 2'b11);  // branch beats load-use
    tbl[14] = hv(0, 0, 0, 0, 0, 1, 1, 1, 4'b0000, 2'b11);  // branch, zero-wait mem

    do_reset("init");
    for (int i = 0; i < 15; i++) apply(tbl[i], $sformatf("vec%0d", i));
    apply(idle(), "post_tbl");

    // Memory wait of 3 cycles with a branch held in E, flushed on release.
    do_reset("mw");
    for (int i = 0; i < 3; i++)
      apply(hv(0, 0, 0, 0, 0, 1, 1, 0, 4'b1111, 2'b00), $sformatf("mw_wait%0d", i));
    apply(hv(0, 0, 0, 0, 0, 1, 1, 1, 4'b0000, 2'b11), "mw_release");
    apply(idle(), "mw_after");
    check("mw.stall_cycles_is_3", 32'(stall_cycles), 32'd3);

    // Timeout: freeze for MEM_TIMEOUT cycles, then release with sticky error.
    do_reset("to");
    for (int i = 0; i < MEM_TIMEOUT; i++)
      apply(hv(0, 0, 0, 0, 0, 0, 1, 0, 4'b1111, 2'b00), $sformatf("to_wait%0d", i));
    apply(hv(0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 2'b00), "to_hit");
    exp_err = 1'b1;
    apply(idle(), "to_after0");
    apply(idle(), "to_after1");
    do_reset("to_clr");
    apply(idle(), "to_cleared");

    // Reset in the middle of a memory wait returns straight to RUN.
    for (int i = 0; i < 2; i++)
      apply(hv(0, 0, 0, 0, 0, 0, 1, 0, 4'b1111, 2'b00), $sformatf("mid_wait%0d", i));
    do_reset("mid");
    apply(idle(), "mid_run");

    // Saturation of both counters.
    lw = hv(0, 7, 7, 1, 1, 0, 0, 0, 4'b1100, 2'b01);
    for (int i = 0; i < 20; i++) apply(lw, $sformatf("sat_lw%0d", i));
    for (int i = 0; i < 18; i++)
      apply(hv(0, 0, 0, 0, 0, 1, 0, 0, 4'b0000, 2'b11), $sformatf("sat_br%0d", i));
    apply(idle(), "sat_end");
    check("sat.stall_cycles_max", 32'(stall_cycles), 32'd15);
    check("sat.flush_events_max", 32'(flush_events), 32'd15);
    do_reset("sat_rst");
    apply(idle(), "sat_cleared");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
